// File: rtl/alu_seq_core.sv
// alu_seq_core: multi-cycle ALU with a start/busy/done handshake.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/NOT/PASS) write their result one edge
// after acceptance; unsigned MUL iterates shift-add for W edges.
// Ports:
//   C      clock, rising edge
//   R      asynchronous active-low reset
//   start  request, sampled only while busy=0
//   op     3-bit opcode, sampled with start
//   A, B   W-bit operands, sampled with start
//   busy   high while an accepted operation is in flight
//   done   one-cycle pulse in the cycle after Y/flags are written
//   Y      2W-bit registered result, held between writes
//   Z      Y == 0
//   CO     carry (ADD) / borrow (SUB)
//   OV     signed overflow (ADD/SUB) or nonzero upper product half (MUL)
module alu_seq_core #(
  parameter int W = 8
) (
  input  logic           C,
  input  logic           R,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] Y,
  output logic           Z,
  output logic           CO,
  output logic           OV
);

  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  state_t state, state_next;

  // Areg is kept 2W wide so it can be shifted left during multiplication.
  logic [2*W-1:0] a_reg;
  logic [W-1:0]   b_reg;
  logic [2:0]     op_reg;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_next;
  logic [W+1:0]   exec_res;   // {co, ov, y_low}
  logic           last_iter;

  // Single-cycle result: returns {co, ov, y_low}.
  function automatic logic [W+1:0] alu_exec(
    input logic [2:0]   f,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0]   wide;
    logic [W-1:0] y;
    logic         co;
    logic         ov;
    wide = '0;
    y    = '0;
    co   = 1'b0;
    ov   = 1'b0;
    case (f)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        y    = wide[W-1:0];
        co   = wide[W];
        ov   = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
      end
      OP_SUB: begin
        // Bit W of the extended difference is the borrow, set iff a < b.
        wide = {1'b0, a} - {1'b0, b};
        y    = wide[W-1:0];
        co   = wide[W];
        ov   = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      default: y = a;   // PASS (MUL never reaches this path)
    endcase
    return {co, ov, y};
  endfunction

  assign exec_res  = alu_exec(op_reg, a_reg[W-1:0], b_reg);
  assign acc_next  = acc + (b_reg[0] ? a_reg : '0);
  assign last_iter = (cnt == CW'(1));
  assign busy      = (state != S_IDLE);

  always_ff @(posedge C or negedge R) begin
    if (!R) state <= S_IDLE;
    else    state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = (op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC:  state_next = S_IDLE;
      S_MUL:   if (last_iter) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
      cnt    <= '0;
      acc    <= '0;
      Y      <= '0;
      Z      <= 1'b0;
      CO     <= 1'b0;
      OV     <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg  <= {{W{1'b0}}, A};
            b_reg  <= B;
            op_reg <= op;
            if (op == OP_MUL) begin
              cnt <= CW'(W);
              acc <= '0;
            end
          end
        end
        S_EXEC: begin
          Y    <= {{W{1'b0}}, exec_res[W-1:0]};
          Z    <= (exec_res[W-1:0] == '0);
          CO   <= exec_res[W+1];
          OV   <= exec_res[W];
          done <= 1'b1;
        end
        S_MUL: begin
          acc   <= acc_next;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt - CW'(1);
          if (last_iter) begin
            Y    <= acc_next;
            Z    <= (acc_next == '0);
            CO   <= 1'b0;
            OV   <= |acc_next[2*W-1:W];
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
